// File: rtl/handshake_debounce.sv
// Synchronises and debounces the handshake slide switch for the decoder's wait instructions.
// Optional HANDSHAKE_EDGE_EN adds registered hs_rise/hs_fall pulses on accepted level changes.
module handshake_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_raw,
  output logic handshake_switch,
  output logic debounce_busy
`ifdef HANDSHAKE_EDGE_EN
  ,
  output logic hs_rise,
  output logic hs_fall
`endif
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("handshake_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("handshake_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   level_r;
  logic                   busy_r;

  logic                   stable_in_s;
  logic                   mis_s;
  logic [CNT_WIDTH-1:0]   cnt_next_s;
  logic                   level_next_s;

  assign stable_in_s = sync_r[SYNC_STAGES-1];

  // Next-state for the consecutive-sample counter and the accepted level
  always_comb begin
    cnt_next_s   = cnt_r;
    level_next_s = level_r;
    mis_s        = (stable_in_s != level_r);
    if (!mis_s) begin
      // Any agreeing sample throws away the partial count.
      cnt_next_s = CNT_ZERO;
    end else if (cnt_r == CNT_MAX) begin
      level_next_s = stable_in_s;
      cnt_next_s   = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Synchroniser chain, counter, level and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], switch_raw};
      cnt_r   <= cnt_next_s;
      level_r <= level_next_s;
      busy_r  <= (cnt_next_s != CNT_ZERO);
    end
  end

  assign handshake_switch = level_r;
  assign debounce_busy    = busy_r;

`ifdef HANDSHAKE_EDGE_EN
  logic rise_r;
  logic fall_r;

  // Edge pulses line up with the cycle the new level appears on handshake_switch
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= level_next_s & ~level_r;
      fall_r <= ~level_next_s & level_r;
    end
  end

  assign hs_rise = rise_r;
  assign hs_fall = fall_r;
`endif

endmodule

// File: tb/tb_handshake_debounce.sv
// Table-driven bench for handshake_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Edge-pulse checks are enabled when HANDSHAKE_EDGE_EN is defined.
module tb_handshake_debounce;

  logic clk = 1'b0;
  logic reset;
  logic switch_raw;
  logic handshake_switch;
  logic debounce_busy;
  logic hs_rise;
  logic hs_fall;

  int tests_run = 0;
  int tests_failed = 0;

  handshake_debounce #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switch_raw(switch_raw),
    .handshake_switch(handshake_switch),
    .debounce_busy(debounce_busy)
`ifdef HANDSHAKE_EDGE_EN
    ,
    .hs_rise(hs_rise),
    .hs_fall(hs_fall)
`endif
  );

`ifndef HANDSHAKE_EDGE_EN
  assign hs_rise = 1'b0;
  assign hs_fall = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic raw;
    logic hs;
    logic busy;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic raw, input logic hs,
                     input logic busy, input logic rise, input logic fall);
    vec_t v;
    v.rst = rst; v.raw = raw; v.hs = hs; v.busy = busy; v.rise = rise; v.fall = fall;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic raw);
    reset = rst;
    switch_raw = raw;
    @(posedge clk);
    #1;
  endtask

  // Drive switch_raw to target and count edges until handshake_switch follows (bounded).
  task automatic measure(input logic target, input string name);
    int n;
    n = 0;
    reset = 1'b0;
    switch_raw = target;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (handshake_switch === target) break;
    end
    tests_run++;
    if (n != 6 || handshake_switch !== target) begin
      tests_failed++;
      $display("FAIL %s: latency %0d edges (level %0b), expected 6 edges", name, n, handshake_switch);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    switch_raw = 1'b0;

    // rst, raw -> hs, busy, rise, fall (values after the edge)
    // reset held with switch high, then first acceptance after release
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // 1 -> 0 held
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 1-cycle high glitch
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 3-cycle high glitch: count reaches the limit as the sample flips back
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset at cnt=2, then a fresh full latency
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // fall then rise, each held
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // reset while the output is high clears it without a fall pulse
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw);
      check($sformatf("v%0d handshake_switch", i), handshake_switch, vecs[i].hs);
      check($sformatf("v%0d debounce_busy", i), debounce_busy, vecs[i].busy);
`ifdef HANDSHAKE_EDGE_EN
      check($sformatf("v%0d hs_rise", i), hs_rise, vecs[i].rise);
      check($sformatf("v%0d hs_fall", i), hs_fall, vecs[i].fall);
`endif
    end

    // Hand-written latency sequences from a clean reset
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("post-reset handshake_switch", handshake_switch, 1'b0);
    check("post-reset debounce_busy", debounce_busy, 1'b0);
    measure(1'b1, "rise latency");
    step(1'b0, 1'b1);
    check("held-high level", handshake_switch, 1'b1);
    check("held-high busy", debounce_busy, 1'b0);
    measure(1'b0, "fall latency");
    step(1'b0, 1'b0);
    check("held-low level", handshake_switch, 1'b0);
    check("held-low busy", debounce_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
